// File: rtl/ysyx_210238_wb_arbiter_if.sv
// Register-file write-port bundle: pipeline write-back request, MDU
// result request, and the registered register-file write.
interface ysyx_210238_wb_arbiter_if;
    logic        i_wb_valid;
    logic        o_wb_ready;
    logic        i_wb_rd_wen;
    logic [4:0]  i_wb_rd_addr;
    logic [63:0] i_wb_rd_data;
    logic        i_wb_mem_read;
    logic [63:0] i_wb_mem_rdata;
    logic        i_md_valid;
    logic        o_md_ready;
    logic [4:0]  i_md_rd_addr;
    logic [63:0] i_md_rd_data;
    logic        o_rd_wen;
    logic [4:0]  o_rd_addr;
    logic [63:0] o_rd_wdata;

    // Arbiter side
    modport slave (
        input  i_wb_valid, i_wb_rd_wen, i_wb_rd_addr, i_wb_rd_data,
               i_wb_mem_read, i_wb_mem_rdata,
               i_md_valid, i_md_rd_addr, i_md_rd_data,
        output o_wb_ready, o_md_ready, o_rd_wen, o_rd_addr, o_rd_wdata
    );

    // Requester / register-file side
    modport master (
        output i_wb_valid, i_wb_rd_wen, i_wb_rd_addr, i_wb_rd_data,
               i_wb_mem_read, i_wb_mem_rdata,
               i_md_valid, i_md_rd_addr, i_md_rd_data,
        input  o_wb_ready, o_md_ready, o_rd_wen, o_rd_addr, o_rd_wdata
    );
endinterface

// File: rtl/ysyx_210238_wb_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, the MDU is
// forced through after STARVE_MAX consecutive blocked cycles. One
// registered write per cycle is presented to the register file.
module ysyx_210238_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    ysyx_210238_wb_arbiter_if.slave        bus
);
    typedef enum logic {PIPE, FORCE_MD} state_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve;
    logic [3:0]  w_starve_nxt;
    logic        w_wb_ready;
    logic        w_md_ready;
    logic        w_wb_xfer;
    logic        w_md_xfer;
    logic        w_md_blocked;
    logic        r_rd_wen;
    logic [4:0]  r_rd_addr;
    logic [63:0] r_rd_wdata;

    // Ready outputs depend only on state and pipeline valid
    always_comb begin
        w_wb_ready = 1'b1;
        w_md_ready = !bus.i_wb_valid;
        if (r_state == FORCE_MD) begin
            w_wb_ready = 1'b0;
            w_md_ready = 1'b1;
        end
    end

    assign w_wb_xfer    = bus.i_wb_valid & w_wb_ready;
    assign w_md_xfer    = bus.i_md_valid & w_md_ready;
    assign w_md_blocked = (r_state == PIPE) & bus.i_md_valid & !w_md_ready;

    // Next state and starvation count
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (w_md_xfer) begin
            w_starve_nxt = '0;
        end else if (w_md_blocked) begin
            w_starve_nxt = r_starve + 4'd1;
        end
        case (r_state)
            PIPE: begin
                if (w_md_blocked && (r_starve + 4'd1 == LP_STARVE_MAX)) begin
                    w_state_nxt = FORCE_MD;
                end
            end
            FORCE_MD: begin
                if (w_md_xfer) begin
                    w_state_nxt = PIPE;
                end
            end
            default: w_state_nxt = PIPE;
        endcase
    end

    // State and starvation counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= PIPE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Registered register-file write; x0 writes are consumed but suppressed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_wen   <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_wdata <= '0;
        end else if (w_wb_xfer) begin
            r_rd_wen   <= bus.i_wb_rd_wen & (bus.i_wb_rd_addr != 5'd0);
            r_rd_addr  <= bus.i_wb_rd_addr;
            r_rd_wdata <= bus.i_wb_mem_read ? bus.i_wb_mem_rdata : bus.i_wb_rd_data;
        end else if (w_md_xfer) begin
            r_rd_wen   <= (bus.i_md_rd_addr != 5'd0);
            r_rd_addr  <= bus.i_md_rd_addr;
            r_rd_wdata <= bus.i_md_rd_data;
        end else begin
            r_rd_wen   <= 1'b0;
        end
    end

    assign bus.o_wb_ready = w_wb_ready;
    assign bus.o_md_ready = w_md_ready;
    assign bus.o_rd_wen   = r_rd_wen;
    assign bus.o_rd_addr  = r_rd_addr;
    assign bus.o_rd_wdata = r_rd_wdata;
endmodule

// File: tb/tb_ysyx_210238_wb_arbiter.sv
// Bench for the register-file write-port arbiter: a per-cycle model
// checked on every falling edge, plus directed scenarios with literal
// expected values.
module tb_ysyx_210238_wb_arbiter;
    localparam int unsigned SMAX = 4;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ysyx_210238_wb_arbiter_if bus ();

    ysyx_210238_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_wait: MDU cycles spent blocked since its last grant. Once it reaches
    // SMAX the MDU owns the port until it is granted.
    int unsigned m_wait = 0;
    logic        m_wen  = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [63:0] m_data = '0;

    function automatic logic exp_wb_ready();
        return m_wait < SMAX;
    endfunction

    function automatic logic exp_md_ready();
        return (m_wait >= SMAX) || !bus.i_wb_valid;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_wait = 0;
            m_wen  = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            logic wr, mr;
            wr = exp_wb_ready();
            mr = exp_md_ready();
            if (bus.i_wb_valid && wr) begin
                m_wen  = bus.i_wb_rd_wen && (bus.i_wb_rd_addr != 0);
                m_addr = bus.i_wb_rd_addr;
                m_data = bus.i_wb_mem_read ? bus.i_wb_mem_rdata : bus.i_wb_rd_data;
            end else if (bus.i_md_valid && mr) begin
                m_wen  = (bus.i_md_rd_addr != 0);
                m_addr = bus.i_md_rd_addr;
                m_data = bus.i_md_rd_data;
            end else begin
                m_wen  = 1'b0;
            end
            if (bus.i_md_valid && mr) m_wait = 0;
            else if (bus.i_md_valid) m_wait = m_wait + 1;
        end
    end

    // Compare process: every falling edge
    always @(negedge i_clk) begin
        chk("wb_ready", {63'd0, bus.o_wb_ready}, {63'd0, exp_wb_ready()});
        chk("md_ready", {63'd0, bus.o_md_ready}, {63'd0, exp_md_ready()});
        chk("rd_wen",   {63'd0, bus.o_rd_wen},   {63'd0, m_wen});
        chk("rd_addr",  {59'd0, bus.o_rd_addr},  {59'd0, m_addr});
        chk("rd_wdata", bus.o_rd_wdata, m_data);
    end

    // ---------------- stimulus ----------------
    logic wb_fire, md_fire, wb_rdy_s;

    task automatic cyc();
        @(negedge i_clk);
        wb_fire  = bus.i_wb_valid & bus.o_wb_ready;
        md_fire  = bus.i_md_valid & bus.o_md_ready;
        wb_rdy_s = bus.o_wb_ready;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic wen, input logic [4:0] a,
                          input logic [63:0] d, input logic mr, input logic [63:0] md);
        bus.i_wb_valid     = v;
        bus.i_wb_rd_wen    = wen;
        bus.i_wb_rd_addr   = a;
        bus.i_wb_rd_data   = d;
        bus.i_wb_mem_read  = mr;
        bus.i_wb_mem_rdata = md;
    endtask

    task automatic set_md(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.i_md_valid   = v;
        bus.i_md_rd_addr = a;
        bus.i_md_rd_data = d;
    endtask

    initial begin
        int blocked;
        int k;
        set_wb(1'b1, 1'b1, 5'd5, 64'h1234, 1'b0, 64'h0);
        set_md(1'b1, 5'd1, 64'h1);
        #1 i_rst_n = 1'b0;
        #1;
        // Reset state with pipeline valid
        chk("rst_wen",   {63'd0, bus.o_rd_wen}, 64'd0);
        chk("rst_addr",  {59'd0, bus.o_rd_addr}, 64'd0);
        chk("rst_wdata", bus.o_rd_wdata, 64'd0);
        chk("rst_wbrdy", {63'd0, bus.o_wb_ready}, 64'd1);
        chk("rst_mdrdy", {63'd0, bus.o_md_ready}, 64'd0);
        set_md(1'b0, 5'd0, 64'h0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        cyc();
        chk("x5_wen",  {63'd0, bus.o_rd_wen}, 64'd1);
        chk("x5_addr", {59'd0, bus.o_rd_addr}, 64'd5);
        chk("x5_data", bus.o_rd_wdata, 64'h1234);

        // Pipeline load selects mem_rdata
        set_wb(1'b1, 1'b1, 5'd10, 64'hAAAA, 1'b1, 64'h5555);
        cyc();
        chk("ld_data", bus.o_rd_wdata, 64'h5555);
        chk("ld_addr", {59'd0, bus.o_rd_addr}, 64'd10);

        // Idle cycle: wen drops, address/data hold
        set_wb(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0);
        cyc();
        chk("idle_wen",  {63'd0, bus.o_rd_wen}, 64'd0);
        chk("idle_data", bus.o_rd_wdata, 64'h5555);

        // Idle pipeline, MDU granted same cycle
        set_md(1'b1, 5'd7, 64'hDEAD);
        #1 chk("md_rdy_same", {63'd0, bus.o_md_ready}, 64'd1);
        cyc();
        set_md(1'b0, 5'd0, 64'h0);
        chk("md_fire", {63'd0, md_fire}, 64'd1);
        chk("x7_addr", {59'd0, bus.o_rd_addr}, 64'd7);
        chk("x7_data", bus.o_rd_wdata, 64'hDEAD);

        // x0 from both ports: handshake completes, write suppressed
        set_wb(1'b1, 1'b1, 5'd0, 64'hFFFF, 1'b0, 64'h0);
        cyc();
        chk("x0wb_fire", {63'd0, wb_fire}, 64'd1);
        chk("x0wb_wen",  {63'd0, bus.o_rd_wen}, 64'd0);
        set_wb(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0);
        set_md(1'b1, 5'd0, 64'hFFFF);
        cyc();
        set_md(1'b0, 5'd0, 64'h0);
        chk("x0md_fire", {63'd0, md_fire}, 64'd1);
        chk("x0md_wen",  {63'd0, bus.o_rd_wen}, 64'd0);

        // Starvation: continuous pipeline traffic plus MDU
        set_md(1'b1, 5'd3, 64'hBEEF);
        k = 0;
        blocked = -1;
        for (int i = 0; i < 20; i++) begin
            set_wb(1'b1, 1'b1, 5'(8 + k), 64'h100 + 64'(k), 1'b0, 64'h0);
            cyc();
            if (wb_fire) k++;
            if (md_fire) begin
                blocked = i;
                break;
            end
        end
        set_md(1'b0, 5'd0, 64'h0);
        chk("starve_blocked", 64'(blocked), 64'd4);
        chk("force_wbrdy", {63'd0, wb_rdy_s}, 64'd0);
        chk("force_addr", {59'd0, bus.o_rd_addr}, 64'd3);
        chk("force_data", bus.o_rd_wdata, 64'hBEEF);
        chk("force_wen",  {63'd0, bus.o_rd_wen}, 64'd1);
        cyc();
        chk("resume_addr", {59'd0, bus.o_rd_addr}, 64'd12);
        chk("resume_data", bus.o_rd_wdata, 64'h104);

        // Reset during FORCE_MD
        set_wb(1'b1, 1'b1, 5'd12, 64'hC0DE, 1'b0, 64'h0);
        set_md(1'b1, 5'd9, 64'h99);
        repeat (4) cyc();
        chk("pre_rst_wbrdy", {63'd0, bus.o_wb_ready}, 64'd0);
        chk("pre_rst_mdrdy", {63'd0, bus.o_md_ready}, 64'd1);
        set_md(1'b0, 5'd0, 64'h0);
        i_rst_n = 1'b0;
        #1 i_rst_n = 1'b1;
        #1;
        chk("post_rst_wbrdy", {63'd0, bus.o_wb_ready}, 64'd1);
        chk("post_rst_wen",   {63'd0, bus.o_rd_wen}, 64'd0);
        set_wb(1'b1, 1'b1, 5'd13, 64'hF00D, 1'b0, 64'h0);
        cyc();
        chk("post_rst_fire", {63'd0, wb_fire}, 64'd1);
        chk("post_rst_data", bus.o_rd_wdata, 64'hF00D);

        set_wb(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0);
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_210238_wb_arbiter.md
# ysyx_210238_wb_arbiter

Register-file write-port arbiter and sequencer. It sits between the pipeline write-back stage and the single register-file write port, and shares that port with the multi-cycle multiply/divide unit (MDU). It performs the load/ALU result select, arbitrates with starvation protection for the MDU, and presents one registered write per cycle to the register file.

## Interface

Parameters:
- `STARVE_MAX`, default 4: consecutive MDU-blocked cycles before the MDU is forced through. Legal range 1..15.

Ports:
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_wb_valid`, in, 1: pipeline write-back request.
- `o_wb_ready`, out, 1: pipeline request accepted this cycle.
- `i_wb_rd_wen`, in, 1: pipeline instruction writes rd.
- `i_wb_rd_addr`, in, 5: pipeline destination register.
- `i_wb_rd_data`, in, 64: ALU/CSR result.
- `i_wb_mem_read`, in, 1: instruction is a load; select `i_wb_mem_rdata`.
- `i_wb_mem_rdata`, in, 64: load data.
- `i_md_valid`, in, 1: MDU result request.
- `o_md_ready`, out, 1: MDU request accepted this cycle.
- `i_md_rd_addr`, in, 5: MDU destination register.
- `i_md_rd_data`, in, 64: MDU result.
- `o_rd_wen`, out, 1: register-file write enable (registered).
- `o_rd_addr`, out, 5: register-file write address (registered).
- `o_rd_wdata`, out, 64: register-file write data (registered).

## Operation

- Handshake on each port: transfer when valid & ready on a rising edge.
  - A requester holds valid and its payload stable until the transfer.
  - At most one transfer per cycle in total.
- FSM states:
  - PIPE (reset state):
    - `o_wb_ready = 1`.
    - `o_md_ready = !i_wb_valid`.
  - FORCE_MD:
    - `o_wb_ready = 0`.
    - `o_md_ready = 1`.
- Ready outputs are combinational from state and `i_wb_valid`. There is no path from `i_md_valid` to any ready.
- Starvation counter `starve`, width 4:
  - In PIPE, when `i_md_valid & !o_md_ready`: `starve <= starve + 1`.
  - On any MDU transfer: `starve <= 0`.
  - In all other cases it holds.
- Transitions:
  - PIPE -> FORCE_MD when `starve` reaches `STARVE_MAX` on the same edge, i.e. the increment makes `starve == STARVE_MAX`.
  - FORCE_MD -> PIPE on the MDU transfer edge.
  - FORCE_MD holds while `i_md_valid` is 0, so a dropped MDU request is illegal and the arbiter does not time out.
- Write register update on each edge:
  - On a pipeline transfer:
    - `o_rd_wen <= i_wb_rd_wen & (i_wb_rd_addr != 0)`.
    - `o_rd_addr <= i_wb_rd_addr`.
    - `o_rd_wdata <= i_wb_mem_read ? i_wb_mem_rdata : i_wb_rd_data`.
  - On an MDU transfer:
    - `o_rd_wen <= (i_md_rd_addr != 0)`.
    - `o_rd_addr <= i_md_rd_addr`.
    - `o_rd_wdata <= i_md_rd_data`.
  - With no transfer: `o_rd_wen <= 0`; `o_rd_addr` and `o_rd_wdata` hold.
- Writes to x0 are accepted (ready asserted, handshake completes) but suppressed at `o_rd_wen`.
- `i_wb_mem_read` only selects the data source. A transfer with `i_wb_rd_wen = 0` is consumed with no write.

## Timing

- Reset (async assert, sync release):
  - State PIPE, `starve = 0`.
  - `o_rd_wen = 0`, `o_rd_addr = 0`, `o_rd_wdata = 0`.
  - Ready outputs follow PIPE: `o_wb_ready = 1`, `o_md_ready = !i_wb_valid`.
- Latency: the register-file write is visible one cycle after the transfer edge, with throughput 1 write/cycle.
- Simultaneous valid:
  - In PIPE, the pipeline wins.
  - In FORCE_MD, the MDU wins and the pipeline stalls for exactly the cycles spent in FORCE_MD (1 if the MDU stays valid).
- Worst-case MDU wait under continuous pipeline traffic: `STARVE_MAX` + 1 cycles from `i_md_valid` to transfer.
- Reset asserted mid-FORCE_MD discards the pending grant. The MDU must re-present its request after reset.
- `starve` never exceeds `STARVE_MAX`; no wrap-around is possible.

## Test plan

- Reset with `i_wb_valid = 1` -> all `o_rd_*` = 0, `o_wb_ready = 1`, `o_md_ready = 0`. After release, the pipeline write (x5, 0x1234) appears with `o_rd_wen = 1` on the next cycle.
- Pipeline load: `i_wb_mem_read = 1`, `rd_data = 0xAAAA`, `mem_rdata = 0x5555`, rd = x10 -> `o_rd_wdata = 0x5555`, `o_rd_addr = 10`, one cycle later.
- Idle pipeline, MDU valid with x7 = 0xDEAD -> `o_md_ready = 1` in the same cycle; the write of x7 appears next cycle; `starve` stays 0.
- Continuous pipeline traffic plus MDU valid, `STARVE_MAX = 4` -> the MDU is blocked 4 cycles. On the 5th cycle `o_wb_ready = 0` and `o_md_ready = 1`, and the MDU write appears. The pipeline resumes the following cycle with no lost or duplicated write.
- rd = x0 on either port with data 0xFFFF -> handshake completes; `o_rd_wen` stays 0.
- Enter FORCE_MD, then pulse `i_rst_n` low -> state returns to PIPE, `o_rd_wen = 0`, `starve = 0`, and the next pipeline request is granted immediately.
